serrx_fifo: RTL and testbench

Parametrised successor to the system's serial console receiver. It deserialises an asynchronous RXD line into characters and buffers them in an on-chip FIFO, so the CPU can drain bursts without losing bytes. It reports parity, framing and overrun errors through sticky flags. It sits between the board RXD pin and the CPU I/O bus, in the same slot as the single-register receiver.

---
 rtl/serrx_pkg.sv | 23 ++
 rtl/serrx_fifo_if.sv | 26 ++
 rtl/serrx_fifo_rx_fifo.sv | 54 +++++
 rtl/serrx_fifo.sv | 155 +++++++++++++++
 tb/tb_serrx_fifo.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serrx_pkg.sv
// Shared definitions for the buffered serial receiver: parity modes, FSM states
// and the parity check used at the stop bit.
package serrx_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  // Narrower characters are zero-extended, which leaves the XOR unchanged.
  function automatic logic parity_ok(input logic [7:0] data, input logic p, input logic odd);
    return ((^data) ^ p) == odd;
  endfunction

endpackage

// File: rtl/serrx_fifo_if.sv
// CPU-side and line-side signals of the buffered serial receiver.
// The master side drives rxd/rd/clr_err; the receiver is the slave.
interface serrx_fifo_if #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 8
);
  logic                   rxd;
  logic                   rd;
  logic                   clr_err;
  logic [DATA_BITS-1:0]   rdata;
  logic                   rxready;
  logic [$clog2(DEPTH):0] count;
  logic                   perr;
  logic                   ferr;
  logic                   overrun;

  modport master (
    output rxd, rd, clr_err,
    input  rdata, rxready, count, perr, ferr, overrun
  );

  modport slave (
    input  rxd, rd, clr_err,
    output rdata, rxready, count, perr, ferr, overrun
  );
endinterface

// File: rtl/serrx_fifo_rx_fifo.sv
// Synchronous show-ahead FIFO; the head is visible on rdata (zero when empty).
// A push while full is accepted only when a pop frees a slot in the same cycle.
module rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign empty  = (r_count == '0);
  assign full   = (r_count == (AW+1)'(DEPTH));
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push & ~w_pop)
        r_count <= r_count + (AW+1)'(1);
      else if (w_pop & ~w_push)
        r_count <= r_count - (AW+1)'(1);
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata;
  end

  assign rdata = empty ? '0 : r_mem[r_rd_ptr];
  assign count = r_count;

endmodule

// File: rtl/serrx_fifo.sv
// Buffered asynchronous serial receiver: synchroniser, bit timer, framing FSM,
// shift register and sticky error flags in front of a show-ahead FIFO.
//
// state    | meaning
// ST_IDLE  | line idle, waiting for a falling edge on rs
// ST_START | half a bit into the start bit; confirm it is still low
// ST_DATA  | sampling data bits LSB first, one per CLK_DIV cycles
// ST_PAR   | sampling the parity bit
// ST_STOP  | sampling the stop bit, then push or flag an error
// ST_BREAK | line held low after a framing error; wait for it to rise
module serrx_fifo #(
  parameter int CLK_DIV   = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int DEPTH     = 8
) (
  input  logic         m_clock,
  input  logic         p_reset,
  serrx_fifo_if.slave  bus
);
  import serrx_pkg::*;

  localparam int TW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] T_FULL = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLK_DIV / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [1:0] PMODE = 2'(PARITY);

  logic                 r_sync1;
  logic                 r_sync2;
  rx_state_e            r_state;
  logic [TW-1:0]        r_timer;
  logic [BW-1:0]        r_bitcnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_ovr;

  logic                 w_rs;
  logic                 w_tc;
  logic                 w_stop_smp;
  logic                 w_par_good;
  logic                 w_push;
  logic                 w_full;
  logic                 w_empty;

  assign w_rs       = r_sync2;
  assign w_tc       = (r_timer == '0);
  assign w_stop_smp = (r_state == ST_STOP) && w_tc;
  assign w_par_good = (PMODE == PAR_NONE) ||
                      parity_ok(8'(r_shift), r_par, PMODE == PAR_ODD);
  assign w_push     = w_stop_smp && w_rs && w_par_good;

  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_state  <= ST_IDLE;
      r_timer  <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
    end else begin
      r_sync1 <= bus.rxd;
      r_sync2 <= r_sync1;
      case (r_state)
        ST_IDLE: begin
          if (!w_rs) begin
            r_state <= ST_START;
            r_timer <= T_HALF;
          end
        end
        ST_START: begin
          if (!w_tc) begin
            r_timer <= r_timer - TW'(1);
          end else if (w_rs) begin
            r_state <= ST_IDLE;
          end else begin
            r_state  <= ST_DATA;
            r_timer  <= T_FULL;
            r_bitcnt <= '0;
          end
        end
        ST_DATA: begin
          if (!w_tc) begin
            r_timer <= r_timer - TW'(1);
          end else begin
            r_shift <= {w_rs, r_shift[DATA_BITS-1:1]};
            r_timer <= T_FULL;
            if (r_bitcnt == LAST_BIT)
              r_state <= (PMODE != PAR_NONE) ? ST_PAR : ST_STOP;
            else
              r_bitcnt <= r_bitcnt + BW'(1);
          end
        end
        ST_PAR: begin
          if (!w_tc) begin
            r_timer <= r_timer - TW'(1);
          end else begin
            r_par   <= w_rs;
            r_timer <= T_FULL;
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          // Leaving mid-stop-bit lets a following start bit be caught early.
          if (!w_tc)
            r_timer <= r_timer - TW'(1);
          else
            r_state <= w_rs ? ST_IDLE : ST_BREAK;
        end
        ST_BREAK: begin
          if (w_rs) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A new error in the same cycle as clr_err wins.
  always_ff @(posedge m_clock) begin
    if (p_reset) begin
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      r_perr <= (w_stop_smp && w_rs && !w_par_good) || (r_perr && !bus.clr_err);
      r_ferr <= (w_stop_smp && !w_rs) || (r_ferr && !bus.clr_err);
      r_ovr  <= (w_push && w_full && !bus.rd) || (r_ovr && !bus.clr_err);
    end
  end

  rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (m_clock),
    .rst   (p_reset),
    .push  (w_push),
    .pop   (bus.rd),
    .wdata (r_shift),
    .rdata (bus.rdata),
    .full  (w_full),
    .empty (w_empty),
    .count (bus.count)
  );

  assign bus.rxready = ~w_empty;
  assign bus.perr    = r_perr;
  assign bus.ferr    = r_ferr;
  assign bus.overrun = r_ovr;

endmodule

// File: tb/tb_serrx_fifo.sv
// Bench for serrx_fifo: one receiver without parity (dut0) and one with even
// parity (dut1), checked against a frame-level queue model.
module tb_serrx_fifo;
  localparam int CLK_DIV = 16;
  localparam int DEPTH   = 4;

  logic m_clock = 1'b0;
  logic p_reset = 1'b1;
  always #5 m_clock = ~m_clock;

  serrx_fifo_if #(.DATA_BITS(8), .DEPTH(DEPTH)) bus0 ();
  serrx_fifo_if #(.DATA_BITS(8), .DEPTH(DEPTH)) bus1 ();

  serrx_fifo #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(0), .DEPTH(DEPTH)) dut0 (
    .m_clock (m_clock),
    .p_reset (p_reset),
    .bus     (bus0)
  );

  serrx_fifo #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(1), .DEPTH(DEPTH)) dut1 (
    .m_clock (m_clock),
    .p_reset (p_reset),
    .bus     (bus1)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit m_perr[2];
  bit m_ferr[2];
  bit m_ovr[2];

  task automatic chk(input string tag, input int obs, input int expv);
    n_chk++;
    if (obs == expv) n_pass++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  function automatic int m_size(input int sel);
    return sel ? q1.size() : q0.size();
  endfunction

  function automatic int m_head(input int sel);
    if (sel) return (q1.size() > 0) ? int'(q1[0]) : 0;
    return (q0.size() > 0) ? int'(q0[0]) : 0;
  endfunction

  function automatic int d_count(input int sel);   return sel ? int'(bus1.count)   : int'(bus0.count);   endfunction
  function automatic int d_rxready(input int sel); return sel ? int'(bus1.rxready) : int'(bus0.rxready); endfunction
  function automatic int d_rdata(input int sel);   return sel ? int'(bus1.rdata)   : int'(bus0.rdata);   endfunction
  function automatic int d_perr(input int sel);    return sel ? int'(bus1.perr)    : int'(bus0.perr);    endfunction
  function automatic int d_ferr(input int sel);    return sel ? int'(bus1.ferr)    : int'(bus0.ferr);    endfunction
  function automatic int d_ovr(input int sel);     return sel ? int'(bus1.overrun) : int'(bus0.overrun); endfunction

  task automatic check_all(input int sel, input string pfx);
    chk({pfx, " count"},   d_count(sel),   m_size(sel));
    chk({pfx, " rxready"}, d_rxready(sel), int'(m_size(sel) > 0));
    chk({pfx, " rdata"},   d_rdata(sel),   m_head(sel));
    chk({pfx, " perr"},    d_perr(sel),    int'(m_perr[sel]));
    chk({pfx, " ferr"},    d_ferr(sel),    int'(m_ferr[sel]));
    chk({pfx, " overrun"}, d_ovr(sel),     int'(m_ovr[sel]));
  endtask

  // Frame-level outcome: framing beats parity beats overrun.
  task automatic model_frame(input int sel, input logic [7:0] d, input bit par_en,
                             input bit pbit, input bit stop_bad);
    if (stop_bad) m_ferr[sel] = 1'b1;
    else if (par_en && ((^d) ^ pbit)) m_perr[sel] = 1'b1;
    else if (m_size(sel) == DEPTH) m_ovr[sel] = 1'b1;
    else if (sel) q1.push_back(d);
    else q0.push_back(d);
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge m_clock);
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel) bus1.rxd = v;
    else bus0.rxd = v;
  endtask

  task automatic send(input int sel, input logic [7:0] d, input bit par_en,
                      input bit pbit, input int stop_low);
    set_line(sel, 1'b0);
    hold(CLK_DIV);
    for (int i = 0; i < 8; i++) begin
      set_line(sel, d[i]);
      hold(CLK_DIV);
    end
    if (par_en) begin
      set_line(sel, pbit);
      hold(CLK_DIV);
    end
    if (stop_low > 0) begin
      set_line(sel, 1'b0);
      hold(stop_low * CLK_DIV);
    end
    set_line(sel, 1'b1);
    hold(CLK_DIV);
  endtask

  task automatic pop(input int sel);
    if (sel) bus1.rd = 1'b1; else bus0.rd = 1'b1;
    hold(1);
    if (sel) bus1.rd = 1'b0; else bus0.rd = 1'b0;
    if (sel) begin if (q1.size() > 0) void'(q1.pop_front()); end
    else begin if (q0.size() > 0) void'(q0.pop_front()); end
  endtask

  task automatic clear(input int sel);
    if (sel) bus1.clr_err = 1'b1; else bus0.clr_err = 1'b1;
    hold(1);
    if (sel) bus1.clr_err = 1'b0; else bus0.clr_err = 1'b0;
    m_perr[sel] = 1'b0;
    m_ferr[sel] = 1'b0;
    m_ovr[sel]  = 1'b0;
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int s = 0; s < 2; s++) begin
      m_perr[s] = 1'b0;
      m_ferr[s] = 1'b0;
      m_ovr[s]  = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [7:0] d;
    bit         bad;
    bit         pb;
    int         npop;

    bus0.rxd = 1'b1; bus0.rd = 1'b0; bus0.clr_err = 1'b0;
    bus1.rxd = 1'b1; bus1.rd = 1'b0; bus1.clr_err = 1'b0;
    model_reset();
    hold(3);
    p_reset = 1'b0;
    hold(2);
    check_all(0, "reset0");
    check_all(1, "reset1");

    // Single character: exact push latency relative to the falling edge.
    fork
      send(0, 8'h41, 1'b0, 1'b0, 0);
      begin
        hold(154);
        chk("lat before push rxready", d_rxready(0), 0);
        hold(1);
        chk("lat at push rxready", d_rxready(0), 1);
        chk("lat at push rdata", d_rdata(0), 'h41);
      end
    join
    model_frame(0, 8'h41, 1'b0, 1'b0, 1'b0);
    check_all(0, "x41");
    pop(0);
    check_all(0, "x41 pop");

    // Burst into a 4-deep FIFO: fifth character overruns.
    for (int i = 1; i <= 5; i++) begin
      d = 8'(i * 'h11);
      send(0, d, 1'b0, 1'b0, 0);
      model_frame(0, d, 1'b0, 1'b0, 1'b0);
    end
    check_all(0, "burst");
    for (int i = 0; i < 5; i++) begin
      pop(0);
      check_all(0, "drain");
    end
    clear(0);
    check_all(0, "clr ovr");

    // Short low glitch is a false start.
    set_line(0, 1'b0);
    hold(6);
    set_line(0, 1'b1);
    hold(200);
    check_all(0, "glitch");

    // Stop bit held low: framing error, then break until the line rises.
    fork
      send(0, 8'h5A, 1'b0, 1'b0, 3);
      begin
        hold(156);
        chk("break ferr", d_ferr(0), 1);
        chk("break count", d_count(0), 0);
        bus0.clr_err = 1'b1;
        hold(1);
        bus0.clr_err = 1'b0;
      end
    join
    hold(200);
    check_all(0, "break idle");
    send(0, 8'h5A, 1'b0, 1'b0, 0);
    model_frame(0, 8'h5A, 1'b0, 1'b0, 1'b0);
    check_all(0, "after break");
    pop(0);

    // Full FIFO with rd in the push cycle: no overrun, new char stored last.
    for (int i = 1; i <= 4; i++) begin
      d = 8'('hA0 + i);
      send(0, d, 1'b0, 1'b0, 0);
      model_frame(0, d, 1'b0, 1'b0, 1'b0);
    end
    check_all(0, "full");
    fork
      send(0, 8'h66, 1'b0, 1'b0, 0);
      begin
        hold(154);
        bus0.rd = 1'b1;
        hold(1);
        bus0.rd = 1'b0;
      end
    join
    void'(q0.pop_front());
    model_frame(0, 8'h66, 1'b0, 1'b0, 1'b0);
    check_all(0, "push+pop full");
    for (int i = 0; i < 4; i++) begin
      pop(0);
      check_all(0, "drain2");
    end

    // Random traffic with interleaved reads and error clears.
    for (int it = 0; it < 24; it++) begin
      npop = $urandom_range(0, 2);
      for (int j = 0; j < npop; j++) begin
        pop(0);
        check_all(0, "rnd pop");
      end
      if ($urandom_range(0, 5) == 0) clear(0);
      d   = 8'($urandom);
      bad = ($urandom_range(0, 6) == 0);
      send(0, d, 1'b0, 1'b0, bad ? 1 : 0);
      model_frame(0, d, 1'b0, 1'b0, bad);
      check_all(0, "rnd frame");
    end

    // Reset in the middle of a character flushes everything.
    set_line(0, 1'b0);
    hold(40);
    p_reset = 1'b1;
    set_line(0, 1'b1);
    hold(1);
    model_reset();
    check_all(0, "mid reset");
    p_reset = 1'b0;
    hold(40);
    send(0, 8'h3C, 1'b0, 1'b0, 0);
    model_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    check_all(0, "post reset");

    // Even parity receiver.
    send(1, 8'h07, 1'b1, 1'b0, 0);
    model_frame(1, 8'h07, 1'b1, 1'b0, 1'b0);
    check_all(1, "par bad");
    send(1, 8'h07, 1'b1, 1'b1, 0);
    model_frame(1, 8'h07, 1'b1, 1'b1, 1'b0);
    check_all(1, "par good");
    pop(1);
    clear(1);
    check_all(1, "par clr");
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        pop(1);
        check_all(1, "rndp pop");
      end
      if ($urandom_range(0, 3) == 0) clear(1);
      d   = 8'($urandom);
      pb  = 1'($urandom_range(0, 1));
      bad = ($urandom_range(0, 7) == 0);
      send(1, d, 1'b1, pb, bad ? 1 : 0);
      model_frame(1, d, 1'b1, pb, bad);
      check_all(1, "rndp frame");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
